// File: rtl/alarm_unit.sv
// alarm_unit: compares the RTC time against a programmed 24 h alarm once per
// second and runs the IDLE / RINGING / SNOOZE state machine with an interrupt.
// Optional feature macro: ALARM_SNOOZE_EN (snooze path and SNOOZE state).
module alarm_unit #(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sec_tick_i,
  input  logic [5:0] cur_sec_i,
  input  logic [5:0] cur_min_i,
  input  logic [5:0] cur_hour_i,
  input  logic [1:0] cur_mode_i,
  input  logic [2:0] cur_day_of_week_i,
  input  logic       cfg_we_i,
  input  logic [5:0] cfg_hour_i,
  input  logic [5:0] cfg_min_i,
  input  logic [6:0] cfg_dow_mask_i,
  input  logic       alarm_en_i,
  input  logic       snooze_i,
  input  logic       stop_i,
  output logic       ring_o,
  output logic       irq_o,
  output logic [1:0] state_o,
  output logic       missed_o
);

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;
  localparam logic [11:0] SNZ_LOAD = 12'(SNOOZE_MIN * 60);
`else
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1
  } state_t;
`endif

  localparam logic [7:0] RING_LIMIT = 8'(RING_SEC);

  state_t     r_state;
  state_t     w_stateNext;
  logic [5:0] r_alHour;
  logic [5:0] r_alMin;
  logic [6:0] r_alMask;
  logic [7:0] r_ringCnt;
  logic [7:0] w_ringCntNext;
  logic [7:0] w_ringInc;
  logic       r_irq;
  logic       w_irqNext;
  logic       r_missed;
  logic       w_missedSet;
  logic [6:0] w_hourNorm;
  logic [7:0] w_maskExt;
  logic       w_match;

`ifdef ALARM_SNOOZE_EN
  logic [11:0] r_snzCnt;
  logic [11:0] w_snzCntNext;
`else
  logic        w_unused;
  assign w_unused = ^{snooze_i, 12'(SNOOZE_MIN)};
`endif

  // Convert the current hour to 24 h form so it compares directly with the alarm hour.
  always_comb begin
    w_hourNorm = {1'b0, cur_hour_i};
    if (cur_mode_i[0]) begin
      if (cur_hour_i == 6'd12) begin
        w_hourNorm = cur_mode_i[1] ? 7'd12 : 7'd0;
      end else if (cur_mode_i[1]) begin
        w_hourNorm = {1'b0, cur_hour_i} + 7'd12;
      end
    end
  end

  // Bit 0 of the extended mask is tied low so that day 0 can never match.
  assign w_maskExt = {r_alMask, 1'b0};
  assign w_match   = sec_tick_i && alarm_en_i && (cur_sec_i == 6'd0)
                   && (r_alMin < 6'd60) && (cur_min_i == r_alMin)
                   && (r_alHour < 6'd24) && (w_hourNorm == {1'b0, r_alHour})
                   && w_maskExt[cur_day_of_week_i];

  assign w_ringInc = r_ringCnt + 8'd1;

  // Next-state, counter and interrupt decisions; disable overrides every state.
  always_comb begin
    w_stateNext   = r_state;
    w_ringCntNext = r_ringCnt;
    w_irqNext     = 1'b0;
    w_missedSet   = 1'b0;
`ifdef ALARM_SNOOZE_EN
    w_snzCntNext  = r_snzCnt;
`endif
    if (!alarm_en_i) begin
      w_stateNext = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_match) begin
            w_stateNext   = ST_RINGING;
            w_ringCntNext = 8'd0;
            w_irqNext     = 1'b1;
          end
        end
        ST_RINGING: begin
          if (stop_i) begin
            w_stateNext = ST_IDLE;
          end
`ifdef ALARM_SNOOZE_EN
          else if (snooze_i) begin
            w_stateNext  = ST_SNOOZE;
            w_snzCntNext = SNZ_LOAD;
          end
`endif
          else if (sec_tick_i) begin
            w_ringCntNext = w_ringInc;
            if (w_ringInc == RING_LIMIT) begin
              w_stateNext = ST_IDLE;
              w_missedSet = 1'b1;
            end
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZE: begin
          if (stop_i) begin
            w_stateNext = ST_IDLE;
          end else if (sec_tick_i) begin
            w_snzCntNext = r_snzCnt - 12'd1;
            if (r_snzCnt == 12'd1) begin
              w_stateNext   = ST_RINGING;
              w_ringCntNext = 8'd0;
              w_irqNext     = 1'b1;
            end
          end
        end
`endif
        default: begin
          w_stateNext = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters, alarm registers and the sticky missed flag; a set beats a clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_ringCnt <= 8'd0;
      r_irq     <= 1'b0;
      r_missed  <= 1'b0;
      r_alHour  <= 6'd0;
      r_alMin   <= 6'd0;
      r_alMask  <= 7'd0;
`ifdef ALARM_SNOOZE_EN
      r_snzCnt  <= 12'd0;
`endif
    end else begin
      r_state   <= w_stateNext;
      r_ringCnt <= w_ringCntNext;
      r_irq     <= w_irqNext;
`ifdef ALARM_SNOOZE_EN
      r_snzCnt  <= w_snzCntNext;
`endif
      if (w_missedSet) begin
        r_missed <= 1'b1;
      end else if (stop_i || cfg_we_i) begin
        r_missed <= 1'b0;
      end
      if (cfg_we_i) begin
        r_alHour <= cfg_hour_i;
        r_alMin  <= cfg_min_i;
        r_alMask <= cfg_dow_mask_i;
      end
    end
  end

  assign ring_o   = (r_state == ST_RINGING);
  assign irq_o    = r_irq;
  assign state_o  = r_state;
  assign missed_o = r_missed;

endmodule

// File: tb/tb_alarm_unit.sv
// tb_alarm_unit: directed scenarios plus randomized traffic for alarm_unit,
// checked against a second-granularity behavioural model of the alarm clock.
module tb_alarm_unit;

  localparam int SNOOZE_MIN = 5;
  localparam int RING_SEC   = 60;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_EN = 1'b1;
`else
  localparam bit SNZ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       secTick = 1'b0;
  logic [5:0] curSec = '0;
  logic [5:0] curMin = '0;
  logic [5:0] curHour = '0;
  logic [1:0] curMode = '0;
  logic [2:0] curDow = 3'd1;
  logic       cfgWe = 1'b0;
  logic [5:0] cfgHour = '0;
  logic [5:0] cfgMin = '0;
  logic [6:0] cfgMask = '0;
  logic       alarmEn = 1'b0;
  logic       snooze = 1'b0;
  logic       stop = 1'b0;
  logic       ring;
  logic       irq;
  logic [1:0] state;
  logic       missed;

  int nChecks = 0;
  int nFails  = 0;

  // Model: state as 0/1/2, seconds rung so far, seconds of snooze left.
  int         mState = 0;
  int         mElapsed = 0;
  int         mSnzLeft = 0;
  bit         mIrq = 1'b0;
  bit         mMissed = 1'b0;
  int         mAlHour = 0;
  int         mAlMin = 0;
  logic [6:0] mAlMask = '0;

  alarm_unit #(.SNOOZE_MIN(SNOOZE_MIN), .RING_SEC(RING_SEC)) dut (
    .clk_i(clk), .rst_i(rst), .sec_tick_i(secTick),
    .cur_sec_i(curSec), .cur_min_i(curMin), .cur_hour_i(curHour),
    .cur_mode_i(curMode), .cur_day_of_week_i(curDow),
    .cfg_we_i(cfgWe), .cfg_hour_i(cfgHour), .cfg_min_i(cfgMin),
    .cfg_dow_mask_i(cfgMask), .alarm_en_i(alarmEn),
    .snooze_i(snooze), .stop_i(stop),
    .ring_o(ring), .irq_o(irq), .state_o(state), .missed_o(missed)
  );

  always #5 clk = ~clk;

  // Does the wall-clock time on the inputs equal the programmed alarm this second?
  function automatic bit modelMatch();
    int h24;
    if (!secTick || !alarmEn || curSec != 6'd0 || curDow == 3'd0) return 1'b0;
    if (curMode[0]) h24 = (int'(curHour) % 12) + (curMode[1] ? 12 : 0);
    else            h24 = int'(curHour);
    return (h24 == mAlHour) && (int'(curMin) == mAlMin) && mAlMask[int'(curDow) - 1];
  endfunction

  // Advance the model by one clock using the current inputs, then step the DUT.
  task automatic applyStimulus();
    bit hit;
    bit setMissed;
    hit = modelMatch();
    setMissed = 1'b0;
    if (rst) begin
      mState = 0; mElapsed = 0; mSnzLeft = 0; mIrq = 1'b0; mMissed = 1'b0;
      mAlHour = 0; mAlMin = 0; mAlMask = '0;
    end else begin
      mIrq = 1'b0;
      if (!alarmEn) begin
        mState = 0;
      end else if (mState == 0) begin
        if (hit) begin mState = 1; mElapsed = 0; mIrq = 1'b1; end
      end else if (mState == 1) begin
        if (stop) mState = 0;
        else if (SNZ_EN && snooze) begin mState = 2; mSnzLeft = SNOOZE_MIN * 60; end
        else if (secTick) begin
          mElapsed++;
          if (mElapsed >= RING_SEC) begin mState = 0; setMissed = 1'b1; end
        end
      end else begin
        if (stop) mState = 0;
        else if (secTick) begin
          mSnzLeft--;
          if (mSnzLeft == 0) begin mState = 1; mElapsed = 0; mIrq = 1'b1; end
        end
      end
      if (setMissed) mMissed = 1'b1;
      else if (stop || cfgWe) mMissed = 1'b0;
      if (cfgWe) begin
        mAlHour = int'(cfgHour); mAlMin = int'(cfgMin); mAlMask = cfgMask;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycle();
    secTick = 1'b0; cfgWe = 1'b0; snooze = 1'b0; stop = 1'b0; rst = 1'b0;
    applyStimulus();
  endtask

  task automatic doTick(input int h, input int m, input int s, input logic [1:0] mode, input int dow);
    curHour = 6'(h); curMin = 6'(m); curSec = 6'(s); curMode = mode; curDow = 3'(dow);
    secTick = 1'b1;
    applyStimulus();
    secTick = 1'b0;
  endtask

  task automatic plainTicks(input int n);
    for (int i = 0; i < n; i++) doTick(9, 15, 5, 2'b00, 3);
  endtask

  task automatic programAlarm(input int h, input int m, input logic [6:0] mask);
    cfgHour = 6'(h); cfgMin = 6'(m); cfgMask = mask; cfgWe = 1'b1;
    applyStimulus();
    cfgWe = 1'b0;
  endtask

  task automatic pulseStop();
    stop = 1'b1;
    applyStimulus();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    nChecks++; if (ring !== 1'b0)    begin nFails++; $display("[TB] FAIL reset_ring: got %0d expected 0", ring); end
    nChecks++; if (irq !== 1'b0)     begin nFails++; $display("[TB] FAIL reset_irq: got %0d expected 0", irq); end
    nChecks++; if (state !== 2'd0)   begin nFails++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
    nChecks++; if (missed !== 1'b0)  begin nFails++; $display("[TB] FAIL reset_missed: got %0d expected 0", missed); end
  endtask

  task automatic test_match_24h();
    alarmEn = 1'b1;
    idleCycle();
    programAlarm(7, 30, 7'h7F);
    doTick(7, 30, 1, 2'b00, 3);
    nChecks++; if (state !== 2'd0) begin nFails++; $display("[TB] FAIL 24h_sec1_state: got %0d expected 0", state); end
    doTick(7, 30, 0, 2'b00, 3);
    nChecks++; if (ring !== 1'b1)  begin nFails++; $display("[TB] FAIL 24h_ring: got %0d expected 1", ring); end
    nChecks++; if (irq !== 1'b1)   begin nFails++; $display("[TB] FAIL 24h_irq: got %0d expected 1", irq); end
    nChecks++; if (state !== 2'd1) begin nFails++; $display("[TB] FAIL 24h_state: got %0d expected 1", state); end
    programAlarm(7, 30, 7'h7F);
    nChecks++; if (irq !== 1'b0)   begin nFails++; $display("[TB] FAIL 24h_irq_once: got %0d expected 0", irq); end
    nChecks++; if (state !== 2'd1) begin nFails++; $display("[TB] FAIL 24h_cfg_keeps_state: got %0d expected 1", state); end
    pulseStop();
    nChecks++; if (state !== 2'd0) begin nFails++; $display("[TB] FAIL 24h_stop_state: got %0d expected 0", state); end
  endtask

  task automatic test_12h();
    programAlarm(19, 0, 7'h7F);
    doTick(7, 0, 0, 2'b01, 3);
    nChecks++; if (state !== 2'd0) begin nFails++; $display("[TB] FAIL 12h_7am_state: got %0d expected 0", state); end
    doTick(7, 0, 0, 2'b11, 3);
    nChecks++; if (state !== 2'd1) begin nFails++; $display("[TB] FAIL 12h_7pm_state: got %0d expected 1", state); end
    pulseStop();
    programAlarm(0, 0, 7'h7F);
    doTick(12, 0, 0, 2'b11, 3);
    nChecks++; if (state !== 2'd0) begin nFails++; $display("[TB] FAIL 12h_noon_state: got %0d expected 0", state); end
    doTick(12, 0, 0, 2'b01, 3);
    nChecks++; if (state !== 2'd1) begin nFails++; $display("[TB] FAIL 12h_midnight_state: got %0d expected 1", state); end
    pulseStop();
  endtask

  task automatic test_weekday();
    programAlarm(7, 30, 7'b0000001);
    doTick(7, 30, 0, 2'b00, 2);
    nChecks++; if (state !== 2'd0) begin nFails++; $display("[TB] FAIL dow_day2_state: got %0d expected 0", state); end
    doTick(7, 30, 0, 2'b00, 0);
    nChecks++; if (state !== 2'd0) begin nFails++; $display("[TB] FAIL dow_day0_state: got %0d expected 0", state); end
    doTick(7, 30, 0, 2'b00, 1);
    nChecks++; if (state !== 2'd1) begin nFails++; $display("[TB] FAIL dow_day1_state: got %0d expected 1", state); end
    nChecks++; if (irq !== 1'b1)   begin nFails++; $display("[TB] FAIL dow_day1_irq: got %0d expected 1", irq); end
    pulseStop();
  endtask

  task automatic test_timeout();
    programAlarm(7, 30, 7'h7F);
    doTick(7, 30, 0, 2'b00, 3);
    plainTicks(RING_SEC - 1);
    nChecks++; if (state !== 2'd1) begin nFails++; $display("[TB] FAIL timeout_early_state: got %0d expected 1", state); end
    nChecks++; if (missed !== 1'b0) begin nFails++; $display("[TB] FAIL timeout_early_missed: got %0d expected 0", missed); end
    cfgWe = 1'b1;
    doTick(9, 15, 5, 2'b00, 3);
    cfgWe = 1'b0;
    nChecks++; if (state !== 2'd0)  begin nFails++; $display("[TB] FAIL timeout_state: got %0d expected 0", state); end
    nChecks++; if (ring !== 1'b0)   begin nFails++; $display("[TB] FAIL timeout_ring: got %0d expected 0", ring); end
    nChecks++; if (missed !== 1'b1) begin nFails++; $display("[TB] FAIL timeout_missed_set_wins: got %0d expected 1", missed); end
    idleCycle();
    nChecks++; if (missed !== 1'b1) begin nFails++; $display("[TB] FAIL timeout_missed_sticky: got %0d expected 1", missed); end
    pulseStop();
    nChecks++; if (missed !== 1'b0) begin nFails++; $display("[TB] FAIL timeout_stop_clears: got %0d expected 0", missed); end
  endtask

`ifdef ALARM_SNOOZE_EN
  task automatic test_snooze();
    doTick(7, 30, 0, 2'b00, 3);
    snooze = 1'b1; applyStimulus(); snooze = 1'b0;
    nChecks++; if (state !== 2'd2) begin nFails++; $display("[TB] FAIL snz_state: got %0d expected 2", state); end
    nChecks++; if (ring !== 1'b0)  begin nFails++; $display("[TB] FAIL snz_ring: got %0d expected 0", ring); end
    plainTicks(SNOOZE_MIN * 60 - 1);
    nChecks++; if (state !== 2'd2) begin nFails++; $display("[TB] FAIL snz_299_state: got %0d expected 2", state); end
    plainTicks(1);
    nChecks++; if (state !== 2'd1) begin nFails++; $display("[TB] FAIL snz_300_state: got %0d expected 1", state); end
    nChecks++; if (irq !== 1'b1)   begin nFails++; $display("[TB] FAIL snz_300_irq: got %0d expected 1", irq); end
    stop = 1'b1; snooze = 1'b1; applyStimulus(); stop = 1'b0; snooze = 1'b0;
    nChecks++; if (state !== 2'd0) begin nFails++; $display("[TB] FAIL snz_stop_priority: got %0d expected 0", state); end
    doTick(7, 30, 0, 2'b00, 3);
    snooze = 1'b1; applyStimulus(); snooze = 1'b0;
    alarmEn = 1'b0;
    idleCycle();
    nChecks++; if (state !== 2'd0) begin nFails++; $display("[TB] FAIL snz_disable_state: got %0d expected 0", state); end
    nChecks++; if (irq !== 1'b0)   begin nFails++; $display("[TB] FAIL snz_disable_irq: got %0d expected 0", irq); end
    alarmEn = 1'b1;
    idleCycle();
  endtask
`else
  task automatic test_snooze();
    doTick(7, 30, 0, 2'b00, 3);
    snooze = 1'b1;
    applyStimulus();
    nChecks++; if (state !== 2'd1) begin nFails++; $display("[TB] FAIL snz_ignored_state: got %0d expected 1", state); end
    plainTicks(3);
    snooze = 1'b0;
    nChecks++; if (state !== 2'd1) begin nFails++; $display("[TB] FAIL snz_ignored_ticks: got %0d expected 1", state); end
    pulseStop();
  endtask
`endif

  task automatic test_disable();
    doTick(7, 30, 0, 2'b00, 3);
    plainTicks(RING_SEC);
    doTick(7, 30, 0, 2'b00, 3);
    nChecks++; if (state !== 2'd1)  begin nFails++; $display("[TB] FAIL dis_rering_state: got %0d expected 1", state); end
    alarmEn = 1'b0;
    idleCycle();
    nChecks++; if (state !== 2'd0)  begin nFails++; $display("[TB] FAIL dis_state: got %0d expected 0", state); end
    nChecks++; if (missed !== 1'b1) begin nFails++; $display("[TB] FAIL dis_missed_kept: got %0d expected 1", missed); end
    doTick(7, 30, 0, 2'b00, 3);
    nChecks++; if (state !== 2'd0)  begin nFails++; $display("[TB] FAIL dis_no_match: got %0d expected 0", state); end
    alarmEn = 1'b1;
    pulseStop();
  endtask

  task automatic test_reset_mid();
    doTick(7, 30, 0, 2'b00, 3);
    plainTicks(RING_SEC);
    doTick(7, 30, 0, 2'b00, 3);
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    nChecks++; if (ring !== 1'b0)   begin nFails++; $display("[TB] FAIL rstmid_ring: got %0d expected 0", ring); end
    nChecks++; if (state !== 2'd0)  begin nFails++; $display("[TB] FAIL rstmid_state: got %0d expected 0", state); end
    nChecks++; if (missed !== 1'b0) begin nFails++; $display("[TB] FAIL rstmid_missed: got %0d expected 0", missed); end
    doTick(7, 30, 0, 2'b00, 3);
    nChecks++; if (state !== 2'd0)  begin nFails++; $display("[TB] FAIL rstmid_regs_cleared: got %0d expected 0", state); end
  endtask

  task automatic test_random();
    int h;
    programAlarm(7, 30, 7'h7F);
    for (int i = 0; i < 6000; i++) begin
      rst     = ($urandom_range(0, 1999) == 0);
      alarmEn = ($urandom_range(0, 499) != 0);
      stop    = ($urandom_range(0, 299) == 0);
      snooze  = ($urandom_range(0, 99) == 0);
      cfgWe   = ($urandom_range(0, 399) == 0);
      cfgHour = 6'($urandom_range(0, 26));
      cfgMin  = 6'($urandom_range(0, 61));
      cfgMask = 7'($urandom_range(0, 127));
      secTick = 1'($urandom_range(0, 1));
      curDow  = 3'($urandom_range(0, 7));
      curMode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0 && mAlHour < 24 && mAlMin < 60) begin
        h = mAlHour;
        curMin = 6'(mAlMin);
        curSec = 6'd0;
      end else begin
        h = $urandom_range(0, 23);
        curMin = 6'($urandom_range(0, 59));
        curSec = 6'($urandom_range(0, 59));
      end
      if (curMode[0]) begin
        curHour = 6'((h % 12 == 0) ? 12 : h % 12);
        curMode[1] = (h >= 12);
      end else begin
        curHour = 6'(h);
      end
      applyStimulus();
      nChecks++; if (ring !== (mState == 1)) begin nFails++; $display("[TB] FAIL rand_ring cycle %0d: got %0d expected %0d", i, ring, mState == 1); end
      nChecks++; if (irq !== mIrq)           begin nFails++; $display("[TB] FAIL rand_irq cycle %0d: got %0d expected %0d", i, irq, mIrq); end
      nChecks++; if (state !== 2'(mState))   begin nFails++; $display("[TB] FAIL rand_state cycle %0d: got %0d expected %0d", i, state, mState); end
      nChecks++; if (missed !== mMissed)     begin nFails++; $display("[TB] FAIL rand_missed cycle %0d: got %0d expected %0d", i, missed, mMissed); end
    end
    rst = 1'b0; secTick = 1'b0; cfgWe = 1'b0; stop = 1'b0; snooze = 1'b0;
  endtask

  // Run every scenario in order, then report totals.
  initial begin
    test_reset();
    test_match_24h();
    test_12h();
    test_weekday();
    test_timeout();
    test_snooze();
    test_disable();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
